// File: rtl/regfile_wr_arbiter_if.sv
// Write-port bus between the four writeback requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface regfile_wr_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  localparam int NREG = 1 << ADDR_W;

  logic [3:0]          req;
  logic [4*ADDR_W-1:0] req_addr;
  logic [4*DATA_W-1:0] req_data;
  logic [3:0]          gnt;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [NREG-1:0]     wr_dec;
  logic [1:0]          ptr;

  modport master (
    output req, req_addr, req_data,
    input  gnt, wr_en, wr_addr, wr_data, wr_dec, ptr
  );

  modport slave (
    input  req, req_addr, req_data,
    output gnt, wr_en, wr_addr, wr_data, wr_dec, ptr
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port among
// ALU, load, link and debug writers; registers the winning write.
module regfile_wr_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wr_arbiter_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);

  logic [3:0]        gnt_q;
  logic              en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [NREG-1:0]   dec_q;
  logic [1:0]        ptr_q;

  logic [3:0]        eff;
  logic              hit;
  logic [1:0]        win;
  logic [1:0]        idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [NREG-1:0]   dec;

  // The requester granted this cycle still shows req; mask it out.
  assign eff = bus.req & ~gnt_q;

  always_comb begin
    hit = 1'b0;
    win = '0;
    idx = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + 2'(k);
      if (!hit && eff[idx]) begin
        hit = 1'b1;
        win = idx;
      end
    end
  end

  assign sel_addr = bus.req_addr[win*ADDR_W +: ADDR_W];
  assign sel_data = bus.req_data[win*DATA_W +: DATA_W];
  assign dec      = NREG'(1) << sel_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q  <= '0;
      en_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      dec_q  <= '0;
      ptr_q  <= '0;
    end else if (hit) begin
      gnt_q  <= 4'b0001 << win;
      addr_q <= sel_addr;
      data_q <= sel_data;
      ptr_q  <= win + 2'd1;
      if (sel_addr == ZR) begin
        en_q  <= 1'b0;
        dec_q <= '0;
      end else begin
        en_q  <= 1'b1;
        dec_q <= dec;
      end
    end else begin
      gnt_q <= '0;
      en_q  <= 1'b0;
      dec_q <= '0;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.wr_en   = en_q;
  assign bus.wr_addr = addr_q;
  assign bus.wr_data = data_q;
  assign bus.wr_dec  = dec_q;
  assign bus.ptr     = ptr_q;
endmodule
